// File: rtl/wb_line_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types (package)
// Purpose  : Shared line/address types and the wishbone line-master state set.
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

  // One cache line and the line-granular address that selects it.
  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_adr;

  // Byte-lane mask covering a whole line.
  localparam logic [15:0] SEL_ALL = 16'hFFFF;

  // Master sequencing: wait for a request, run the bus cycle, report.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_master_state_t;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/wishbone.sv
`default_nettype none
// ============================================================================
// Module   : wishbone (interface)
// Purpose  : Line-wide wishbone link between the L1 line master and the L2.
// Revision : 1.0 - initial release
// ============================================================================
interface wishbone;
  import lc3b_types::*;

  logic         CYC;
  logic         STB;
  logic         WE;
  logic [15:0]  SEL;
  lc3b_line_adr ADR;
  lc3b_line     DAT_M;
  lc3b_line     DAT_S;
  logic         ACK;
  logic         RTY;

  modport master (
    output CYC, STB, WE, SEL, ADR, DAT_M,
    input  ACK, RTY, DAT_S
  );

  modport slave (
    input  CYC, STB, WE, SEL, ADR, DAT_M,
    output ACK, RTY, DAT_S
  );

endinterface : wishbone
`default_nettype wire

// File: rtl/wb_line_master_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones; clear beats increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count events, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/wb_line_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_line_master
// Purpose  : Converts the L1 line-request handshake into wishbone cycles
//            toward the L2, with timeout abort and statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module wb_line_master
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_address,
  input  lc3b_line         mem_wdata,
  input  logic [15:0]      mem_byte_enable,
  output lc3b_line         mem_rdata,
  output logic             mem_resp,
  output logic             mem_err,
  wishbone.master          wb,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  wb_master_state_t  r_state;
  wb_master_state_t  w_next_state;

  // Transaction context captured when a request is accepted.
  lc3b_line_adr      r_adr;
  logic              r_we;
  logic [15:0]       r_sel;
  lc3b_line          r_dat;
  lc3b_line          r_rdata;
  logic              r_err;
  logic [WAIT_W-1:0] r_wait;

  logic              w_start;
  logic              w_ack_done;
  logic              w_timeout;
  logic              w_stall;
  logic              w_wait_inc;
  logic              w_txn_done;

  // The line offset bits never reach the bus; lines are always whole.
  logic              w_unused_adr_lsbs;
  assign w_unused_adr_lsbs = ^mem_address[3:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the single-cycle event strobes it implies.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_ack_done   = 1'b0;
    w_timeout    = 1'b0;
    w_stall      = 1'b0;
    w_wait_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) begin
          w_next_state = BUS;
          w_start      = 1'b1;
        end
      end
      BUS: begin
        if (wb.ACK) begin
          // ACK wins even if the slave also raised RTY.
          w_next_state = DONE;
          w_ack_done   = 1'b1;
        end else begin
          w_stall = wb.RTY;
          if (r_wait == WAIT_LAST) begin
            w_next_state = DONE;
            w_timeout    = 1'b1;
          end else begin
            w_wait_inc = 1'b1;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request capture, wait counting, error flag and read-line capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      if (w_start) begin
        r_adr  <= mem_address[15:4];
        // Write has priority when both request lines are raised.
        r_we   <= mem_write;
        r_sel  <= mem_write ? mem_byte_enable : SEL_ALL;
        r_dat  <= mem_wdata;
        r_err  <= 1'b0;
        r_wait <= '0;
      end
      if (w_wait_inc) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_ack_done && !r_we) begin
        r_rdata <= wb.DAT_S;
      end
    end
  end

  assign w_txn_done = (r_state == DONE);

  // Bus and L1 outputs come straight from registered state.
  assign wb.CYC    = (r_state == BUS);
  assign wb.STB    = (r_state == BUS);
  assign wb.WE     = r_we;
  assign wb.SEL    = r_sel;
  assign wb.ADR    = r_adr;
  assign wb.DAT_M  = r_dat;
  assign mem_rdata = r_rdata;
  assign mem_resp  = w_txn_done;
  assign mem_err   = w_txn_done & r_err;

  sat_counter #(.WIDTH(CNT_W)) u_txn_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (stat_clear),
    .inc   (w_txn_done),
    .count (txn_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (stat_clear),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (stat_clear),
    .inc   (w_timeout),
    .count (timeout_cnt)
  );

endmodule : wb_line_master
`default_nettype wire

// File: tb/tb_wb_line_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_line_master
// Purpose  : Directed self-checking bench for wb_line_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_line_master;
  import lc3b_types::*;

  localparam int TO    = 8;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int S_TO  = 70000;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (short timeout) ----------------
  logic          rst, mem_read, mem_write, stat_clear;
  logic [15:0]   mem_address, mem_byte_enable;
  lc3b_line      mem_wdata, mem_rdata;
  logic          mem_resp, mem_err;
  logic [CW-1:0] txn_cnt, stall_cnt, timeout_cnt;
  wishbone wb();

  wb_line_master #(.TIMEOUT(TO), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .mem_err(mem_err), .wb(wb),
    .stat_clear(stat_clear), .txn_cnt(txn_cnt), .stall_cnt(stall_cnt),
    .timeout_cnt(timeout_cnt)
  );

  // ---------------- saturation DUT (long timeout) ----------------
  logic          s_read, s_clear;
  lc3b_line      s_rdata;
  logic          s_resp, s_err;
  logic [CW-1:0] s_txn, s_stall, s_to;
  wishbone wb_s();

  wb_line_master #(.TIMEOUT(S_TO), .CNT_W(CW)) u_dut_sat (
    .clk(clk), .rst(rst), .mem_read(s_read), .mem_write(1'b0),
    .mem_address(16'h7770), .mem_wdata('0),
    .mem_byte_enable(16'h0000), .mem_rdata(s_rdata),
    .mem_resp(s_resp), .mem_err(s_err), .wb(wb_s),
    .stat_clear(s_clear), .txn_cnt(s_txn), .stall_cnt(s_stall),
    .timeout_cnt(s_to)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // ---------------- behavioural model of the main DUT ----------------
  // Transaction-level view: is a bus cycle open, how long has it waited,
  // is a response owed this cycle, and what the counters must read.
  bit           model_on = 1'b0;
  bit           m_fresh;
  bit           m_bus, m_resp, m_err;
  int           m_waited;
  bit           m_we;
  logic [11:0]  m_adr;
  logic [15:0]  m_sel;
  lc3b_line     m_dat, m_rdata;
  int           m_txn, m_stall, m_to;

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("cyc",       {127'b0, wb.CYC},   {127'b0, m_bus});
        check("stb",       {127'b0, wb.STB},   {127'b0, m_bus});
        check("mem_resp",  {127'b0, mem_resp}, {127'b0, m_resp});
        check("mem_err",   {127'b0, mem_err},  {127'b0, m_resp & m_err});
        check("mem_rdata", mem_rdata, m_rdata);
        check("txn_cnt",     128'(txn_cnt),     128'(m_txn));
        check("stall_cnt",   128'(stall_cnt),   128'(m_stall));
        check("timeout_cnt", 128'(timeout_cnt), 128'(m_to));
        if (m_bus || m_fresh) begin
          check("adr",   128'(wb.ADR), 128'(m_adr));
          check("we",    {127'b0, wb.WE}, {127'b0, m_we});
          check("sel",   128'(wb.SEL), 128'(m_sel));
          check("dat_m", wb.DAT_M, m_dat);
        end
      end
      // Advance the model using the inputs the next edge will sample.
      if (rst) begin
        model_on = 1'b1; m_fresh = 1'b1;
        m_bus = 0; m_resp = 0; m_err = 0; m_waited = 0; m_we = 0;
        m_adr = '0; m_sel = '0; m_dat = '0; m_rdata = '0;
        m_txn = 0; m_stall = 0; m_to = 0;
      end else if (model_on) begin
        bit go_resp, go_err;
        int ntxn, nst, nto;
        go_resp = 0; go_err = 0;
        ntxn = m_txn; nst = m_stall; nto = m_to;
        m_fresh = 1'b0;
        if (m_resp) ntxn = sat(ntxn + 1);
        if (m_bus) begin
          if (wb.ACK) begin
            if (!m_we) m_rdata = wb.DAT_S;
            m_bus = 0; go_resp = 1;
          end else begin
            if (wb.RTY) nst = sat(nst + 1);
            if (m_waited + 1 >= TO) begin
              m_bus = 0; go_resp = 1; go_err = 1; nto = sat(nto + 1);
            end else begin
              m_waited++;
            end
          end
        end else if (!m_resp && (mem_read || mem_write)) begin
          m_bus = 1; m_waited = 0;
          m_we  = mem_write;
          m_adr = mem_address[15:4];
          m_sel = mem_write ? mem_byte_enable : 16'hFFFF;
          m_dat = mem_wdata;
        end
        m_resp = go_resp; m_err = go_err;
        if (stat_clear) begin
          ntxn = 0; nst = 0; nto = 0;
        end
        m_txn = ntxn; m_stall = nst; m_to = nto;
      end
    end
  end

  // Watchdog: the bench must never hang.
  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  localparam lc3b_line RD1 = 128'hDEADBEEF_00112233_44556677_DEADBEEF;
  localparam lc3b_line WD2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam lc3b_line WD3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  // ---------------- directed stimulus ----------------
  initial begin
    int n, resps, gap, falls, rises;
    bit prev_stb;
    rst = 1; mem_read = 0; mem_write = 0; stat_clear = 0;
    mem_address = '0; mem_byte_enable = '0; mem_wdata = '0;
    wb.ACK = 0; wb.RTY = 0; wb.DAT_S = '0;
    s_read = 0; s_clear = 0;
    wb_s.ACK = 0; wb_s.RTY = 0; wb_s.DAT_S = '0;
    tick(); tick(); tick();
    rst = 0;
    check("rst_stb", {127'b0, wb.STB}, 128'd0);
    check("rst_txn", 128'(txn_cnt), 128'd0);
    tick();

    // 1: read with three RTY cycles, then ACK
    mem_read = 1; mem_address = 16'h1234;
    tick();
    wb.RTY = 1;
    check("t1_adr", 128'(wb.ADR), 128'h123);
    check("t1_sel", 128'(wb.SEL), 128'hFFFF);
    tick(); tick(); tick();
    wb.RTY = 0; wb.ACK = 1; wb.DAT_S = RD1;
    check("t1_no_resp_yet", {127'b0, mem_resp}, 128'd0);
    tick();
    wb.ACK = 0; wb.DAT_S = '0; mem_read = 0;
    check("t1_resp",  {127'b0, mem_resp}, 128'd1);
    check("t1_rdata", mem_rdata, RD1);
    check("t1_err",   {127'b0, mem_err}, 128'd0);
    tick();
    check("t1_stall", 128'(stall_cnt), 128'd3);
    check("t1_txn",   128'(txn_cnt), 128'd1);

    // 2: write acked in the first bus cycle
    mem_write = 1; mem_address = 16'h0A50; mem_byte_enable = 16'h00F0; mem_wdata = WD2;
    tick();
    wb.ACK = 1;
    check("t2_we",  {127'b0, wb.WE}, 128'd1);
    check("t2_sel", 128'(wb.SEL), 128'h00F0);
    check("t2_adr", 128'(wb.ADR), 128'h0A5);
    check("t2_dat", wb.DAT_M, WD2);
    tick();
    wb.ACK = 0; mem_write = 0;
    check("t2_resp",  {127'b0, mem_resp}, 128'd1);
    check("t2_rdata", mem_rdata, RD1);
    tick();

    // 3: read and write together -> one write transaction
    mem_read = 1; mem_write = 1; mem_address = 16'h0B07; mem_byte_enable = 16'h0F0F; mem_wdata = WD3;
    tick();
    wb.ACK = 1;
    check("t3_we", {127'b0, wb.WE}, 128'd1);
    resps = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_resp) resps++;
      wb.ACK = 0; mem_read = 0; mem_write = 0;
    end
    check("t3_one_resp", 128'(resps), 128'd1);

    // 4: timeout with the slave stalling forever
    stat_clear = 1;
    tick();
    stat_clear = 0;
    mem_read = 1; mem_address = 16'h4440;
    tick();
    wb.RTY = 1;
    n = 0;
    while (wb.STB && n < 20) begin
      n++;
      tick();
    end
    check("t4_bus_cycles", 128'(n), 128'd8);
    check("t4_resp", {127'b0, mem_resp}, 128'd1);
    check("t4_err",  {127'b0, mem_err},  128'd1);
    wb.RTY = 0; mem_read = 0;
    tick();
    check("t4_timeout_cnt", 128'(timeout_cnt), 128'd1);
    check("t4_txn", 128'(txn_cnt), 128'd1);

    // 5: reset in the middle of a bus cycle
    mem_read = 1; mem_address = 16'h5550;
    tick();
    wb.RTY = 1;
    tick();
    rst = 1;
    tick();
    rst = 0; mem_read = 0; wb.RTY = 0;
    check("t5_cyc",  {127'b0, wb.CYC}, 128'd0);
    check("t5_resp", {127'b0, mem_resp}, 128'd0);
    check("t5_cnts", {80'b0, txn_cnt, stall_cnt, timeout_cnt}, 128'd0);
    tick();

    // 6: back-to-back reads keep at least one STB-low cycle between them
    mem_read = 1; mem_address = 16'h6000;
    resps = 0; gap = 0; falls = 0; rises = 0; prev_stb = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_resp) resps++;
      if (prev_stb && !wb.STB) falls++;
      if (!prev_stb && wb.STB) rises++;
      if (falls == 1 && rises == 1 && !wb.STB) gap++;
      prev_stb = wb.STB;
      wb.ACK = wb.STB;
      wb.DAT_S = 128'(i);
      if (resps == 2) mem_read = 0;
    end
    wb.ACK = 0; mem_read = 0;
    check("t6_two_resps", 128'(resps), 128'd2);
    check("t6_gap_ok", {127'b0, (gap >= 1)}, 128'd1);
    tick(); tick();

    // 6b: stall counter saturation and clear priority on the long-timeout DUT
    s_read = 1;
    tick();
    wb_s.RTY = 1;
    n = 0;
    while (s_stall != 16'hFFFF && n < 68000) begin
      n++;
      tick();
    end
    check("sat_reach", 128'(s_stall), 128'hFFFF);
    tick();
    check("sat_hold", 128'(s_stall), 128'hFFFF);
    s_clear = 1;
    tick();
    s_clear = 0;
    check("sat_clear", 128'(s_stall), 128'd0);
    tick();
    check("sat_after_clear", 128'(s_stall), 128'd1);
    wb_s.RTY = 0; wb_s.ACK = 1;
    tick();
    wb_s.ACK = 0; s_read = 0;
    check("sat_resp", {127'b0, s_resp}, 128'd1);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_line_master
`default_nettype wire
